// File: rtl/sram_cycle_ctrl.sv
// rtl/sram_cycle_ctrl.sv - single-access SRAM cycle sequencer with programmable strobe width (optional SRAM_AUTOINC_EN address counter)
module sram_cycle_ctrl #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_inc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [WAIT_W-1:0] wait_states,
    output logic              done,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_out_q, dq_out_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   acc_addr;
    logic                accept;

    assign accept = (state_q == IDLE) && req_valid;

`ifdef SRAM_AUTOINC_EN
    logic [ADDR_W-1:0] inc_q, inc_d;

    // Address source select and next auto-increment value, both resolved at the accept edge
    always_comb begin
        inc_d    = inc_q;
        acc_addr = req_inc ? inc_q : req_addr;
        if (accept) begin
            inc_d = acc_addr + ADDR_ONE;
        end
    end

    // Auto-increment counter register; wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_q <= '0;
        end else begin
            inc_q <= inc_d;
        end
    end
`else
    logic unused_req_inc;
    assign unused_req_inc = req_inc;

    // Without the counter every access uses the supplied address
    always_comb begin
        acc_addr = req_addr;
    end
`endif

    // Next-state and next-output decode; every pin is registered so it changes only on clk
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        rsp_d    = rsp_q;
        dq_oe_d  = dq_oe_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = SETUP;
                    we_d     = req_we;
                    cnt_d    = wait_states;
                    addr_d   = acc_addr;
                    dq_out_d = req_wdata;
                    ce_n_d   = 1'b0;
                    dq_oe_d  = req_we;
                end
            end
            SETUP: begin
                state_d = STROBE;
                oe_n_d  = we_q;
                we_n_d  = !we_q;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rsp_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                state_d = IDLE;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered pin drivers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dq_out_q <= '0;
            rsp_q    <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            rsp_q    <= rsp_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            done_q   <= done_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign done        = done_q;
    assign rsp_data    = rsp_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule
